// File: rtl/segundos_unidades_tick_if.sv
// Bus bundle for the seconds-units countdown stage: control inputs and digit/status outputs.
// The ext_tick signal exists only when EXT_TICK_EN is defined.
interface segundos_unidades_tick_if;
    logic [3:0] data;
    logic       loadn;
    logic       en;
    logic       upper_zero;
`ifdef EXT_TICK_EN
    logic       ext_tick;
`endif
    logic [3:0] units;
    logic       tick;
    logic       tc;
    logic       zero;
    logic       done;

    modport master (
        output data, loadn, en, upper_zero,
`ifdef EXT_TICK_EN
        output ext_tick,
`endif
        input  units, tick, tc, zero, done
    );

    modport slave (
        input  data, loadn, en, upper_zero,
`ifdef EXT_TICK_EN
        input  ext_tick,
`endif
        output units, tick, tc, zero, done
    );
endinterface

// File: rtl/segundos_unidades_tick.sv
// Seconds-units stage of the mm:ss countdown: prescaler timebase plus BCD mod-10 down counter.
// Define EXT_TICK_EN to drop the internal prescaler and take the tick from bus.ext_tick.
module segundos_unidades_tick #(
    parameter int unsigned PRESCALE = 50000000,
    parameter int unsigned PW       = 26
) (
    input logic clk,
    input logic clear,
    segundos_unidades_tick_if.slave bus
);

    logic [3:0] units_q, units_d;
    logic       tick_q, tick_d;
    logic       done_q, done_d;
    logic       running;
`ifndef EXT_TICK_EN
    logic [PW-1:0] presc_q, presc_d;
`endif

    assign running = bus.en & ~done_q;

    always_comb begin
        units_d = units_q;
        tick_d  = 1'b0;
        done_d  = done_q;
`ifndef EXT_TICK_EN
        presc_d = presc_q;
`endif
        if (!bus.loadn) begin
            units_d = (bus.data > 4'd9) ? 4'd9 : bus.data;
            done_d  = 1'b0;
`ifndef EXT_TICK_EN
            presc_d = '0;
`endif
        end else if (running) begin
`ifdef EXT_TICK_EN
            tick_d = bus.ext_tick;
`else
            if (presc_q == PW'(PRESCALE - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
`endif
            // Digit moves on the edge that ends the registered tick cycle.
            if (tick_q) begin
                if (units_q != 4'd0) begin
                    units_d = units_q - 4'd1;
                end else if (!bus.upper_zero) begin
                    units_d = 4'd9;
                end else begin
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            units_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
`ifndef EXT_TICK_EN
            presc_q <= '0;
`endif
        end else begin
            units_q <= units_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
`ifndef EXT_TICK_EN
            presc_q <= presc_d;
`endif
        end
    end

    assign bus.units = units_q;
    assign bus.tick  = tick_q;
    assign bus.done  = done_q;
    assign bus.zero  = (units_q == 4'd0);
    assign bus.tc    = tick_q & (units_q == 4'd0) & ~bus.upper_zero;

endmodule

// File: tb/tb_segundos_unidades_tick.sv
// Directed bench for segundos_unidades_tick with PRESCALE=4: vector table plus corner sequences.
// Build with EXT_TICK_EN defined to exercise the external-tick variant instead.
module tb_segundos_unidades_tick;

    logic clk;
    logic clear;
    int   n_checks;
    int   n_fail;

    segundos_unidades_tick_if bus ();

    segundos_unidades_tick #(
        .PRESCALE(4),
        .PW      (3)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       loadn;
        logic [3:0] data;
        logic       en;
        logic       uz;
        logic [3:0] units;
        logic       tick;
        logic       tc;
        logic       zero;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] u, input logic t,
                           input logic c, input logic z, input logic d);
        chk({name, ".units"}, 32'(bus.units), 32'(u));
        chk({name, ".tick"},  32'(bus.tick),  32'(t));
        chk({name, ".tc"},    32'(bus.tc),    32'(c));
        chk({name, ".zero"},  32'(bus.zero),  32'(z));
        chk({name, ".done"},  32'(bus.done),  32'(d));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ln, input logic [3:0] dt, input logic e, input logic u,
                       input logic [3:0] eu, input logic et, input logic ec, input logic ez,
                       input logic ed);
        vec_t v;
        v.loadn = ln; v.data = dt; v.en = e; v.uz = u;
        v.units = eu; v.tick = et; v.tc = ec; v.zero = ez; v.done = ed;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ln, input logic [3:0] dt, input logic e, input logic u);
        bus.loadn = ln;
        bus.data = dt;
        bus.en = e;
        bus.upper_zero = u;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int tc_seen;
        n_checks = 0;
        n_fail   = 0;
        clear    = 1'b1;
        drive(1'b1, 4'd0, 1'b0, 1'b0);
`ifdef EXT_TICK_EN
        bus.ext_tick = 1'b0;
`endif
        #2;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("reset_held", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        clear = 1'b0;

`ifdef EXT_TICK_EN
        drive(1'b0, 4'd1, 1'b1, 1'b0);
        step();
        chk_all("ext_load", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.loadn = 1'b1;
        bus.ext_tick = 1'b1;
        step();
        chk_all("ext_tick1", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.ext_tick = 1'b0;
        step();
        chk_all("ext_dec", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.ext_tick = 1'b1;
        step();
        chk_all("ext_tick2", 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.ext_tick = 1'b0;
        step();
        chk_all("ext_wrap", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.en = 1'b0;
        bus.ext_tick = 1'b1;
        step();
        chk_all("ext_paused", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.ext_tick = 1'b0;
`else
        // Countdown 3,2,1,0,9 with a tick every 4 cycles, then a clamped load.
        add(0, 4'd3, 1, 0, 4'd3, 0, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd3, 0, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd3, 0, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd3, 0, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd3, 1, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd2, 0, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd2, 0, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd2, 0, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd2, 1, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd1, 0, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd1, 0, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd1, 0, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd1, 1, 0, 0, 0);
        add(1, 4'd0, 1, 0, 4'd0, 0, 0, 1, 0);
        add(1, 4'd0, 1, 0, 4'd0, 0, 0, 1, 0);
        add(1, 4'd0, 1, 0, 4'd0, 0, 0, 1, 0);
        add(1, 4'd0, 1, 0, 4'd0, 1, 1, 1, 0);
        add(1, 4'd0, 1, 0, 4'd9, 0, 0, 0, 0);
        add(0, 4'd12, 0, 0, 4'd9, 0, 0, 0, 0);
        add(0, 4'd15, 1, 0, 4'd9, 0, 0, 0, 0);
        add(0, 4'd0, 1, 0, 4'd0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].loadn, vecs[i].data, vecs[i].en, vecs[i].uz);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].units, vecs[i].tick,
                    vecs[i].tc, vecs[i].zero, vecs[i].done);
        end

        // End of countdown: 2,1,0 then done on the third tick; tc must never rise.
        drive(1'b0, 4'd2, 1'b1, 1'b1);
        step();
        bus.loadn = 1'b1;
        tc_seen = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.tc) tc_seen++;
        end
        chk_all("end_third_tick", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("end_done", 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.tc || bus.tick || bus.units != 4'd0 || !bus.done) tc_seen++;
        end
        chk("end_frozen_no_tc", 32'(tc_seen), 32'd0);
        drive(1'b0, 4'd4, 1'b0, 1'b0);
        step();
        chk_all("load_clears_done", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pause keeps the prescaler phase: two cycles in, seven paused, two more to tick.
        drive(1'b0, 4'd5, 1'b1, 1'b0);
        step();
        bus.loadn = 1'b1;
        step();
        step();
        bus.en = 1'b0;
        tc_seen = 0;
        for (int c = 0; c < 7; c++) begin
            step();
            if (bus.tick || bus.units != 4'd5) tc_seen++;
        end
        chk("pause_hold", 32'(tc_seen), 32'd0);
        bus.en = 1'b1;
        step();
        chk_all("resume1", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("resume2_tick", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("resume_dec", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load coincident with a tick: load wins, prescaler restarts.
        drive(1'b0, 4'd5, 1'b1, 1'b0);
        step();
        bus.loadn = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk_all("pre_tick", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd7, 1'b1, 1'b0);
        step();
        chk_all("load_over_tick", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.loadn = 1'b1;
        for (int c = 0; c < 3; c++) step();
        chk_all("restart_no_tick", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("restart_tick", 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("restart_dec", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous clear in the middle of a clock period.
        step();
        step();
        #2;
        clear = 1'b1;
        #1;
        chk_all("async_clear", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("clear_held", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        clear = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
